// File: rtl/polar_info_mapper.sv
// Serial-to-parallel polar u-vector builder: scatters K info bits into the
// non-frozen positions of an N-bit vector. Optional framing check: POLAR_MAPPER_LAST_CHECK_EN.
module polar_info_mapper #(
    parameter int unsigned  N         = 32,
    parameter int unsigned  K         = 16,
    parameter logic [N-1:0] INFO_MASK = 32'hFFFF_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s_data,
    input  logic         s_valid,
    output logic         s_ready,
`ifdef POLAR_MAPPER_LAST_CHECK_EN
    input  logic         s_last,
    output logic         err,
`endif
    output logic [N-1:0] m_data,
    output logic         m_valid,
    input  logic         m_ready
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = $clog2(K + 1);

    // Packed table: entry j (PW bits at j*PW) is the index of the j-th set mask bit.
    function automatic logic [K*PW-1:0] pos_table();
        logic [K*PW-1:0] t;
        int unsigned     j;
        t = '0;
        j = 0;
        for (int unsigned i = 0; i < N; i++) begin
            if (INFO_MASK[i] && (j < K)) begin
                t[j*PW +: PW] = PW'(i);
                j++;
            end
        end
        return t;
    endfunction

    localparam logic [K*PW-1:0] POS = pos_table();

    generate
        if ($countones(INFO_MASK) != K) begin : g_mask_check
            $error("polar_info_mapper: popcount(INFO_MASK) must equal K");
        end
    endgenerate

    typedef enum logic {COLLECT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N-1:0]    buf_q, buf_d;
    logic [N-1:0]    m_data_q, m_data_d;
    logic            m_valid_q, m_valid_d;
`ifdef POLAR_MAPPER_LAST_CHECK_EN
    logic            err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q;
`ifdef POLAR_MAPPER_LAST_CHECK_EN
        err_d     = 1'b0;
`endif
        case (state_q)
            COLLECT: begin
                if (s_valid) begin
                    for (int unsigned i = 0; i < K; i++) begin
                        if (cnt_q == CW'(i)) buf_d[POS[i*PW +: PW]] = s_data;
                    end
                    if (cnt_q == CW'(K - 1)) begin
                        state_d   = HOLD;
                        m_data_d  = buf_d;
                        m_valid_d = 1'b1;
`ifdef POLAR_MAPPER_LAST_CHECK_EN
                        err_d     = ~s_last;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
`ifdef POLAR_MAPPER_LAST_CHECK_EN
                        // Early last: drop the partial vector and restart framing.
                        if (s_last) begin
                            err_d = 1'b1;
                            buf_d = '0;
                            cnt_d = '0;
                        end
`endif
                    end
                end
            end
            HOLD: begin
                if (m_ready) begin
                    state_d   = COLLECT;
                    m_valid_d = 1'b0;
                    buf_d     = '0;
                    cnt_d     = '0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= COLLECT;
            cnt_q     <= '0;
            buf_q     <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
`ifdef POLAR_MAPPER_LAST_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            buf_q     <= buf_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
`ifdef POLAR_MAPPER_LAST_CHECK_EN
            err_q     <= err_d;
`endif
        end
    end

    assign s_ready = (state_q == COLLECT);
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
`ifdef POLAR_MAPPER_LAST_CHECK_EN
    assign err     = err_q;
`endif

endmodule
